hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall sequencer and branch flush control for a five-stage MIPS pipeline
// Optional feature macro: HAZARD_PERF_CNT_EN (adds stall_cycles / flush_count counters)
module hazard_ctrl #(
  parameter int LOAD_STALL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction_ID,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        branch_taken,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  // The counter is only 4 bits wide, so longer stalls cannot be represented.
  if (LOAD_STALL < 1 || LOAD_STALL > 15) begin : g_bad_load_stall
    $error("hazard_ctrl: LOAD_STALL=%0d outside 1..15", LOAD_STALL);
  end

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;

  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [5:0] w_opcode;
  logic       w_uses_rt;
  logic       w_hazard;
  logic       w_unused_imm;

  assign w_rs     = Instruction_ID[25:21];
  assign w_rt     = Instruction_ID[20:16];
  assign w_opcode = Instruction_ID[31:26];
  // The immediate / funct field never takes part in hazard detection.
  assign w_unused_imm = ^Instruction_ID[15:0];

  // Only R-type, beq, bne and sw read rt as a source; for loads and immediates rt is a destination.
  assign w_uses_rt = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                     (w_opcode == 6'h05) || (w_opcode == 6'h2B);

  assign w_hazard = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == w_rs) || (w_uses_rt && (ID_EX_Rt == w_rt)));

  // State and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and pipeline control; a load-use hazard outranks a taken branch, and reset forces a bubble.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    stall_active = 1'b0;
    case (r_state)
      RUN: begin
        if (w_hazard) begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            w_state_next = STALL;
            w_cnt_next   = 4'(LOAD_STALL - 1);
          end
        end else if (branch_taken) begin
          IF_ID_flush = 1'b1;
        end
      end
      STALL: begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        stall_active = 1'b1;
        w_cnt_next   = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
        w_cnt_next   = 4'd0;
      end
    endcase
    if (!rst_n) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b1;
      stall_active = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (!PC_write) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (IF_ID_flush) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (LOAD_STALL = 1, 3, 4, 2)
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        memread = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        br = 1'b0;

  // Index 0: LOAD_STALL=1, 1: LOAD_STALL=3, 2: LOAD_STALL=4, 3: LOAD_STALL=2
  logic [3:0]  pcw, ifw, fl, bub, st;
  logic [31:0] sc [4];
  logic [31:0] fc [4];

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADD_R8 = 32'h01095020;  // add $10,$8,$9
  localparam logic [31:0] ADD_R0 = 32'h00095020;  // add $10,$0,$9
  localparam logic [31:0] LW_RT8 = 32'h8D280000;  // lw  $8,0($9)
  localparam logic [31:0] SW_RT8 = 32'hAD280000;  // sw  $8,0($9)
  localparam logic [31:0] BEQ_RT8 = 32'h11280000; // beq $9,$8,0

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(1)) u_ls1 (
    .clk(clk), .rst_n(rst_n), .Instruction_ID(instr), .ID_EX_MemRead(memread),
    .ID_EX_Rt(ex_rt), .branch_taken(br), .PC_write(pcw[0]), .IF_ID_write(ifw[0]),
    .IF_ID_flush(fl[0]), .ID_EX_bubble(bub[0]), .stall_active(st[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[0]), .flush_count(fc[0])
`endif
  );

  hazard_ctrl #(.LOAD_STALL(3)) u_ls3 (
    .clk(clk), .rst_n(rst_n), .Instruction_ID(instr), .ID_EX_MemRead(memread),
    .ID_EX_Rt(ex_rt), .branch_taken(br), .PC_write(pcw[1]), .IF_ID_write(ifw[1]),
    .IF_ID_flush(fl[1]), .ID_EX_bubble(bub[1]), .stall_active(st[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[1]), .flush_count(fc[1])
`endif
  );

  hazard_ctrl #(.LOAD_STALL(4)) u_ls4 (
    .clk(clk), .rst_n(rst_n), .Instruction_ID(instr), .ID_EX_MemRead(memread),
    .ID_EX_Rt(ex_rt), .branch_taken(br), .PC_write(pcw[2]), .IF_ID_write(ifw[2]),
    .IF_ID_flush(fl[2]), .ID_EX_bubble(bub[2]), .stall_active(st[2])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[2]), .flush_count(fc[2])
`endif
  );

  hazard_ctrl #(.LOAD_STALL(2)) u_ls2 (
    .clk(clk), .rst_n(rst_n), .Instruction_ID(instr), .ID_EX_MemRead(memread),
    .ID_EX_Rt(ex_rt), .branch_taken(br), .PC_write(pcw[3]), .IF_ID_write(ifw[3]),
    .IF_ID_flush(fl[3]), .ID_EX_bubble(bub[3]), .stall_active(st[3])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[3]), .flush_count(fc[3])
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rt, input logic [31:0] ins, input logic b);
    memread = mr;
    ex_rt   = rt;
    instr   = ins;
    br      = b;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd8, ADD_R8, 1'b1);
    checks++; if ({pcw[0], ifw[0], fl[0], bub[0], st[0]} !== 5'b00010) begin failures++; $display("FAIL reset_outputs got=%b exp=00010", {pcw[0], ifw[0], fl[0], bub[0], st[0]}); end
    checks++; if (fl[1] !== 1'b0) begin failures++; $display("FAIL reset_no_flush got=%b exp=0", fl[1]); end
    idle(0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if ({pcw[1], ifw[1], fl[1], bub[1], st[1]} !== 5'b11000) begin failures++; $display("FAIL after_reset_run got=%b exp=11000", {pcw[1], ifw[1], fl[1], bub[1], st[1]}); end
  endtask

  task automatic test_load_use_ls1();
    idle(6);
    drive(1'b1, 5'd8, ADD_R8, 1'b0);
    checks++; if ({pcw[0], ifw[0], bub[0], st[0]} !== 4'b0010) begin failures++; $display("FAIL ls1_stall got=%b exp=0010", {pcw[0], ifw[0], bub[0], st[0]}); end
    cyc();
    drive(1'b0, 5'd8, ADD_R8, 1'b0);
    checks++; if ({pcw[0], ifw[0], bub[0], st[0]} !== 4'b1100) begin failures++; $display("FAIL ls1_resume got=%b exp=1100", {pcw[0], ifw[0], bub[0], st[0]}); end
  endtask

  task automatic test_multi_stall_ls3();
    idle(6);
    drive(1'b1, 5'd8, ADD_R8, 1'b0);
    checks++; if ({pcw[1], st[1]} !== 2'b00) begin failures++; $display("FAIL ls3_cycle1 got=%b exp=00", {pcw[1], st[1]}); end
    cyc();
    drive(1'b0, 5'd8, ADD_R8, 1'b0);
    checks++; if ({pcw[1], bub[1], st[1]} !== 3'b011) begin failures++; $display("FAIL ls3_cycle2 got=%b exp=011", {pcw[1], bub[1], st[1]}); end
    cyc();
    checks++; if ({pcw[1], bub[1], st[1]} !== 3'b011) begin failures++; $display("FAIL ls3_cycle3 got=%b exp=011", {pcw[1], bub[1], st[1]}); end
    cyc();
    checks++; if ({pcw[1], ifw[1], bub[1], st[1]} !== 4'b1100) begin failures++; $display("FAIL ls3_resume got=%b exp=1100", {pcw[1], ifw[1], bub[1], st[1]}); end
  endtask

  task automatic test_reg0_and_rt();
    idle(6);
    drive(1'b1, 5'd0, ADD_R0, 1'b0);
    checks++; if (pcw[0] !== 1'b1) begin failures++; $display("FAIL rt_zero_no_stall got=%b exp=1", pcw[0]); end
    drive(1'b1, 5'd8, LW_RT8, 1'b0);
    checks++; if (pcw[0] !== 1'b1) begin failures++; $display("FAIL lw_rt_no_stall got=%b exp=1", pcw[0]); end
    drive(1'b1, 5'd8, SW_RT8, 1'b0);
    checks++; if ({pcw[0], bub[0]} !== 2'b01) begin failures++; $display("FAIL sw_rt_stall got=%b exp=01", {pcw[0], bub[0]}); end
    drive(1'b1, 5'd8, BEQ_RT8, 1'b0);
    checks++; if ({pcw[0], bub[0]} !== 2'b01) begin failures++; $display("FAIL beq_rt_stall got=%b exp=01", {pcw[0], bub[0]}); end
    drive(1'b0, 5'd8, SW_RT8, 1'b0);
    checks++; if (pcw[0] !== 1'b1) begin failures++; $display("FAIL no_memread_no_stall got=%b exp=1", pcw[0]); end
  endtask

  task automatic test_branch();
    idle(6);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    checks++; if ({pcw[0], ifw[0], fl[0], bub[0]} !== 4'b1110) begin failures++; $display("FAIL branch_flush got=%b exp=1110", {pcw[0], ifw[0], fl[0], bub[0]}); end
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    checks++; if (fl[0] !== 1'b0) begin failures++; $display("FAIL branch_flush_one_cycle got=%b exp=0", fl[0]); end
    // A branch depending on the load stalls first on the LOAD_STALL=3 instance, then flushes.
    drive(1'b1, 5'd8, BEQ_RT8, 1'b1);
    checks++; if ({pcw[1], fl[1], bub[1]} !== 3'b001) begin failures++; $display("FAIL prio_hazard got=%b exp=001", {pcw[1], fl[1], bub[1]}); end
    cyc();
    drive(1'b0, 5'd8, BEQ_RT8, 1'b1);
    checks++; if ({fl[1], st[1]} !== 2'b01) begin failures++; $display("FAIL prio_stall2 got=%b exp=01", {fl[1], st[1]}); end
    cyc();
    checks++; if ({fl[1], st[1]} !== 2'b01) begin failures++; $display("FAIL prio_stall3 got=%b exp=01", {fl[1], st[1]}); end
    cyc();
    checks++; if ({pcw[1], fl[1], st[1]} !== 3'b110) begin failures++; $display("FAIL prio_flush_after got=%b exp=110", {pcw[1], fl[1], st[1]}); end
  endtask

  task automatic test_back_to_back();
    idle(6);
    drive(1'b1, 5'd8, ADD_R8, 1'b0);
    cyc();
    cyc();
    checks++; if ({pcw[1], st[1]} !== 2'b01) begin failures++; $display("FAIL b2b_stall3 got=%b exp=01", {pcw[1], st[1]}); end
    cyc();
    checks++; if ({pcw[1], bub[1], st[1]} !== 3'b010) begin failures++; $display("FAIL b2b_new_hazard got=%b exp=010", {pcw[1], bub[1], st[1]}); end
    cyc();
    checks++; if ({pcw[1], st[1]} !== 2'b01) begin failures++; $display("FAIL b2b_new_stall got=%b exp=01", {pcw[1], st[1]}); end
  endtask

  task automatic test_reset_mid_stall();
    idle(6);
    drive(1'b1, 5'd8, ADD_R8, 1'b0);
    checks++; if (pcw[2] !== 1'b0) begin failures++; $display("FAIL ls4_cycle1 got=%b exp=0", pcw[2]); end
    cyc();
    drive(1'b0, 5'd8, ADD_R8, 1'b0);
    checks++; if ({pcw[2], st[2]} !== 2'b01) begin failures++; $display("FAIL ls4_cycle2 got=%b exp=01", {pcw[2], st[2]}); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({pcw[2], ifw[2], fl[2], bub[2], st[2]} !== 5'b00010) begin failures++; $display("FAIL ls4_in_reset got=%b exp=00010", {pcw[2], ifw[2], fl[2], bub[2], st[2]}); end
    cyc();
    rst_n = 1'b1;
    #1;
    checks++; if ({pcw[2], ifw[2], fl[2], bub[2], st[2]} !== 5'b11000) begin failures++; $display("FAIL ls4_after_release got=%b exp=11000", {pcw[2], ifw[2], fl[2], bub[2], st[2]}); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if ({sc[2], fc[2]} !== 64'd0) begin failures++; $display("FAIL ls4_counters_zero got=%0d/%0d exp=0/0", sc[2], fc[2]); end
`endif
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    idle(6);
    rst_n = 1'b0;
    #1;
    checks++; if ({sc[3], fc[3]} !== 64'd0) begin failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", sc[3], fc[3]); end
    cyc();
    rst_n = 1'b1;
    for (int h = 0; h < 2; h++) begin
      drive(1'b1, 5'd8, ADD_R8, 1'b0);
      cyc();
      idle(2);
    end
    for (int b = 0; b < 3; b++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1);
      cyc();
      idle(1);
    end
    checks++; if (sc[3] !== 32'd4) begin failures++; $display("FAIL perf_stall_cycles got=%0d exp=4", sc[3]); end
    checks++; if (fc[3] !== 32'd3) begin failures++; $display("FAIL perf_flush_count got=%0d exp=3", fc[3]); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use_ls1();
    test_multi_stall_ls3();
    test_reg0_and_rt();
    test_branch();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
